// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: word width, fetch FSM states, FIFO entry.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        StFetch,
        StFull,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; flush empties it, push with pop while full is legal.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // Qualify requests: a pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while not counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited requests to instruction memory, in-order responses
// buffered in a prefetch FIFO, redirect flushes and kills in-flight responses.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirect halts fetch and raises
// a sticky fetch_misalign_o until an aligned redirect or reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            fetch_misalign_o,
`endif
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;  // PC of the next live response
    logic [CW-1:0]   out_q, out_d;          // granted, not yet responded (incl. killed)
    logic [CW-1:0]   kill_q, kill_d;        // responses still to be discarded
    logic [CW-1:0]   fifo_count, count_next, live_next;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redir_pc;
    logic            fire, pop, killed, push, misalign_redir;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head_entry;

    assign redir_pc = redirect_pc_i & ~32'h3;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;
    assign misalign_redir   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign fetch_misalign_o = misalign_q;
`else
    assign misalign_redir = 1'b0;
`endif

    // Request only in StFetch; a same-cycle redirect always suppresses it.
    assign imem_req_o  = !rst && !redirect_i && (state_q == StFetch);
    assign imem_addr_o = pc_q;

    // Next-state for counters, PCs and FSM; StFetch means credit is available next cycle.
    always_comb begin
        fire       = imem_req_o && imem_gnt_i;
        pop        = instr_valid_o && instr_ready_i;
        killed     = imem_rvalid_i && (redirect_i || (kill_q != '0));
        push       = imem_rvalid_i && !killed && (!fifo_full || pop);
        out_d      = out_q + CW'(fire) - CW'(imem_rvalid_i);
        kill_d     = redirect_i ? out_d
                                : kill_q - CW'(imem_rvalid_i && (kill_q != '0));
        count_next = redirect_i ? '0 : fifo_count + CW'(push) - CW'(pop);
        live_next  = out_d - kill_d;
        credit_used = {1'b0, count_next} + {1'b0, live_next};

        pc_d      = redirect_i ? redir_pc : (fire ? pc_q + 32'd4 : pc_q);
        resp_pc_d = redirect_i ? redir_pc : (push ? resp_pc_q + 32'd4 : resp_pc_q);

        state_d = state_q;
        if (redirect_i) begin
            state_d = misalign_redir ? StHalt : StFetch;
        end else if (state_q != StHalt) begin
            state_d = (credit_used < CREDIT) ? StFetch : StFull;
        end

        push_entry.instr = imem_rdata_i;
        push_entry.pc    = resp_pc_q;
    end

    // Fetch FSM and its bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            kill_q    <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            kill_q    <= kill_d;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_i) misalign_q <= misalign_redir;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random memory timing, checked against a
// stream-level model (expected fetch address, expected delivered PC sequence, credit).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign_o;
`endif

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign_o(fetch_misalign_o),
`endif
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned gnt_pct  = 100;
    int unsigned rdy_pct  = 100;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;

    // Reference model state
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_exp_pc   = RESET_PC;
    int          m_avail    = 0;  // delivered live words not yet consumed
    int          m_inflight = 0;  // granted since last redirect minus consumed
    int unsigned m_epoch    = 0;
    bit          m_halt     = 1'b0;

    // Observations for directed checks
    int unsigned n_dropped   = 0;
    bit          s_valid, s_req, s_redir;
    logic [31:0] s_addr;
    bit          after_redir = 1'b0;
    logic [31:0] first_pop_pc;
    logic [31:0] prev_pop_pc = 32'h1;
    bit          wrap_seen   = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("rst_misalign", 32'(fetch_misalign_o), 32'd0);
`endif
        mem_q.delete();
        m_fetch_pc  = RESET_PC;
        m_exp_pc    = RESET_PC;
        m_avail     = 0;
        m_inflight  = 0;
        m_epoch++;
        m_halt      = 1'b0;
        after_redir = 1'b1;
        cyc += 2;
        rst = 1'b0;
    endtask

    // One clock cycle starting just after a falling edge.
    // mode 0: no redirect; 1: redirect; 2: redirect only if rvalid coincides with a pop.
    task automatic cycle(input int mode, input logic [31:0] target);
        bit       fire, pop, redir;
        mem_req_t e;
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        redir = (mode == 1) || (mode == 2 && imem_rvalid_i && instr_valid_o && instr_ready_i);
        redirect_i    = redir;
        redirect_pc_i = target;
        #1;
        check_eq("imem_req", 32'(imem_req_o),
                 32'(!redir && !m_halt && (m_inflight < int'(DEPTH))));
        if (imem_req_o) check_eq("imem_addr", imem_addr_o, m_fetch_pc);
        check_eq("instr_valid", 32'(instr_valid_o), 32'(m_avail > 0));
        pop = instr_valid_o && instr_ready_i;
        if (pop) begin
            check_eq("instr_pc", instr_pc_o, m_exp_pc);
            check_eq("instr_data", instr_o, mem_word(m_exp_pc));
        end
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("misalign", 32'(fetch_misalign_o), 32'(m_halt));
`endif
        s_valid = instr_valid_o;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_redir = redir;
        fire    = imem_req_o && imem_gnt_i;

        if (pop) begin
            if (after_redir) begin
                first_pop_pc = instr_pc_o;
                after_redir  = 1'b0;
            end
            if (instr_pc_o == 32'h0 && prev_pop_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            prev_pop_pc = instr_pc_o;
            m_exp_pc += 32'd4;
            m_avail--;
            m_inflight--;
        end
        if (imem_rvalid_i) begin
            e = mem_q.pop_front();
            if (e.epoch == m_epoch && !redir) m_avail++;
            else n_dropped++;
        end
        if (fire) begin
            mem_q.push_back('{addr: imem_addr_o, due: cyc + $urandom_range(lat_max, lat_min),
                              epoch: m_epoch});
            m_fetch_pc += 32'd4;
            m_inflight++;
        end
        if (redir) begin
            m_epoch++;
            m_avail      = 0;
            m_inflight   = 0;
            m_fetch_pc   = target & ~32'h3;
            m_exp_pc     = m_fetch_pc;
            after_redir  = 1'b1;
            first_pop_pc = 32'hDEAD_BEEF;
`ifdef FETCH_MISALIGN_CHK_EN
            m_halt = (target[1:0] != 2'b00);
`endif
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    initial begin
        int          first_v;
        int unsigned drops0, kexp;
        bit          hit;

        @(negedge clk);
        do_reset();

        // Boot: zero-wait memory, always ready
        first_v = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 32'h0);
            if (i < 3) check_eq("boot_addr", s_addr, RESET_PC + 32'(4 * i));
            if (s_valid && first_v < 0) first_v = i;
        end
        check_eq("first_valid_cycle", 32'(first_v), 32'd2);

        // Consumer stalls: credit fills to DEPTH
        rdy_pct = 0;
        repeat (10) cycle(0, 32'h0);
        check_eq("stall_req_low", 32'(s_req), 32'd0);
        check_eq("stall_inflight", 32'(m_inflight), 32'(DEPTH));
        rdy_pct = 100;
        repeat (3) cycle(0, 32'h0);

        // Slow memory, redirect with exactly two requests in flight
        lat_min = 3;
        lat_max = 3;
        gnt_pct = 0;
        cycle(1, 32'h80);
        repeat (8) cycle(0, 32'h0);
        gnt_pct = 100;
        repeat (2) cycle(0, 32'h0);
        gnt_pct = 0;
        check_eq("outstanding_before_redirect", 32'(mem_q.size()), 32'd2);
        drops0 = n_dropped;
        cycle(1, 32'h100);
        gnt_pct = 100;
        repeat (14) cycle(0, 32'h0);
        check_eq("slow_dropped", 32'(n_dropped - drops0), 32'd2);
        check_eq("slow_first_pc", first_pop_pc, 32'h100);

        // Minimum redirect latency with zero-wait memory
        lat_min = 1;
        lat_max = 1;
        repeat (5) cycle(0, 32'h0);
        cycle(1, 32'h40);
        cycle(0, 32'h0);
        check_eq("redir_lat_n1", 32'(s_valid), 32'd0);
        cycle(0, 32'h0);
        check_eq("redir_lat_n2", 32'(s_valid), 32'd0);
        cycle(0, 32'h0);
        check_eq("redir_lat_n3", 32'(s_valid), 32'd1);
        repeat (3) cycle(0, 32'h0);
        check_eq("redir_first_pc", first_pop_pc, 32'h40);

        // Redirect coinciding with both rvalid and a pop
        lat_min = 2;
        lat_max = 2;
        hit     = 1'b0;
        drops0  = n_dropped;
        kexp    = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            drops0 = n_dropped;
            kexp   = mem_q.size();
            cycle(2, 32'h300);
            hit = s_redir;
        end
        check_eq("coincident_hit", 32'(hit), 32'd1);
        repeat (10) cycle(0, 32'h0);
        check_eq("coincident_dropped", 32'(n_dropped - drops0), 32'(kexp));
        check_eq("coincident_first_pc", first_pop_pc, 32'h300);

        // Grant withheld: address holds; then sequential fetch wraps through zero
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 0;
        cycle(1, 32'hFFFF_FFF0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 32'h0);
            check_eq("gnt_hold_req", 32'(s_req), 32'd1);
            check_eq("gnt_hold_addr", s_addr, 32'hFFFF_FFF0);
        end
        gnt_pct   = 100;
        wrap_seen = 1'b0;
        repeat (12) cycle(0, 32'h0);
        check_eq("pc_wrap", 32'(wrap_seen), 32'd1);

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect halts until an aligned redirect
        cycle(1, 32'h102);
        repeat (4) cycle(0, 32'h0);
        check_eq("halt_no_req", 32'(s_req), 32'd0);
        check_eq("halt_flag", 32'(fetch_misalign_o), 32'd1);
        cycle(1, 32'h200);
        repeat (6) cycle(0, 32'h0);
        check_eq("halt_cleared", 32'(fetch_misalign_o), 32'd0);
        check_eq("halt_resume_pc", first_pop_pc, 32'h200);
`endif

        // Random traffic: grant/ready rates, latency, redirects and occasional reset
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                rdy_pct = $urandom_range(100, 20);
            end
            if ($urandom_range(999) < 2) do_reset();
            else if ($urandom_range(99) < 3) cycle(1, rand_target());
            else cycle(0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
